// File: rtl/sub86_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sub86_bus_pkg: shared size codes, MMIO offsets and status bit indices    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sub86_bus_pkg;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_BYTE_ALT = 2'b10;
  localparam logic [1:0] SZ_WORD     = 2'b11;
  localparam logic [1:0] SZ_DWORD    = 2'b01;

  localparam logic [1:0] OUTD   = 2'd0;
  localparam logic [1:0] TIMER  = 2'd1;
  localparam logic [1:0] STATUS = 2'd2;

  localparam int OVF  = 0;
  localparam int COLL = 1;

  function automatic logic [2:0] size_bytes(input logic [1:0] ben);
    case (ben)
      SZ_BYTE, SZ_BYTE_ALT: return 3'd1;
      SZ_WORD:              return 3'd2;
      SZ_DWORD:             return 3'd4;
      default:              return 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub86_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sub86_byte_fifo: first-word-fall-through byte FIFO, async active-low rst |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sub86_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  output logic                     o_full,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [7:0]    r_store [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;

  assign w_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PW-2:0] == r_rd[PW-2:0]) && (r_wr[PW-1] != r_rd[PW-1]);
  assign o_valid = !w_empty;
  assign o_count = r_wr - r_rd;
  assign o_head  = w_empty ? 8'h00 : r_store[r_rd[PW-2:0]];

  // A pop frees a slot in the same edge, so a push into a full FIFO still lands
  assign w_pop  = i_pop && !w_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push && i_rst_n) begin
      r_store[r_wr[PW-2:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sub86_bus_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sub86_bus_resp: fetch/data responder with byte memory, MMIO FIFO, timer  |
// | Optional: define SUB86_TIMER_EN to implement the TIMER counter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sub86_bus_resp
  import sub86_bus_pkg::*;
#(
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [31:0]   IA,
  output logic [15:0]   ID,
  input  logic [31:0]   A,
  input  logic [31:0]   Q,
  output logic [31:0]   D,
  input  logic          WEN,
  input  logic [1:0]    BEN,
  input  logic          LD_WE,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [7:0]    LD_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [7:0]    OUT_DATA
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    r_mem [2**AW];
  logic [1:0]    r_status;

  logic [AW-1:0] w_ia0, w_ia1;
  logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [2:0]    w_sz;
  logic [31:0]   w_mem_rd;
  logic          w_wr;
  logic          w_mem_we;
  logic          w_mm_we;
  logic [1:0]    w_off;
  logic          w_push;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic [7:0]    w_cnt8;
  logic          w_ovf;
  logic          w_coll;
  logic [1:0]    w_st_clr;
  logic [31:0]   w_timer;
  logic          w_unused;

  assign w_unused = ^{A[30:AW], IA[31:AW]};

  assign w_ia0 = IA[AW-1:0];
  assign w_ia1 = w_ia0 + AW'(1);
  assign w_a0  = A[AW-1:0];
  assign w_a1  = w_a0 + AW'(1);
  assign w_a2  = w_a0 + AW'(2);
  assign w_a3  = w_a0 + AW'(3);
  assign w_sz  = size_bytes(BEN);

  // Fetch places the lower-addressed byte in the high half
  assign ID       = {r_mem[w_ia0], r_mem[w_ia1]};
  assign w_mem_rd = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};

  assign w_wr     = !WEN && RSTN;
  assign w_mem_we = w_wr && !A[31];
  assign w_mm_we  = w_wr && A[31];
  assign w_off    = A[3:2];
  assign w_push   = w_mm_we && (w_off == OUTD);
  assign w_ovf    = w_push && w_full && !(OUT_VALID && OUT_READY);
  assign w_coll   = w_mem_we && LD_WE;
  assign w_st_clr = (w_mm_we && (w_off == STATUS)) ? Q[1:0] : 2'b00;
  assign w_cnt8   = 8'(w_count);

  // Loader has priority; a colliding CPU write is dropped in its entirety
  always_ff @(posedge CLK) begin
    if (RSTN && LD_WE) begin
      r_mem[LD_ADDR] <= LD_DATA;
    end else if (w_mem_we) begin
      r_mem[w_a0] <= Q[7:0];
      if (w_sz != 3'd1) r_mem[w_a1] <= Q[15:8];
      if (w_sz == 3'd4) begin
        r_mem[w_a2] <= Q[23:16];
        r_mem[w_a3] <= Q[31:24];
      end
    end
  end

  sub86_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_push  (w_push),
    .i_data  (Q[7:0]),
    .o_full  (w_full),
    .i_pop   (OUT_READY),
    .o_valid (OUT_VALID),
    .o_head  (OUT_DATA),
    .o_count (w_count)
  );

  // A set event in the same cycle overrides a write-1-to-clear
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_status <= 2'b00;
    end else begin
      r_status[OVF]  <= w_ovf  | (r_status[OVF]  & ~w_st_clr[OVF]);
      r_status[COLL] <= w_coll | (r_status[COLL] & ~w_st_clr[COLL]);
    end
  end

`ifdef SUB86_TIMER_EN
  logic [31:0] r_timer;
  logic        w_tm_we;

  assign w_tm_we = w_mm_we && (w_off == TIMER);
  assign w_timer = r_timer;

  // The loaded value counts during the write cycle, so it reads back as Q+1
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_timer <= 32'h0;
    end else if (w_tm_we) begin
      r_timer <= Q + 32'd1;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`else
  assign w_timer = 32'h0;
`endif

  always_comb begin
    D = 32'h0;
    if (!A[31]) begin
      case (w_sz)
        3'd1:    D = {24'h0, w_mem_rd[7:0]};
        3'd2:    D = {16'h0, w_mem_rd[15:0]};
        default: D = w_mem_rd;
      endcase
    end else begin
      case (w_off)
        OUTD:    D = {16'h0, w_cnt8, 6'b0, w_full, !OUT_VALID};
        TIMER:   D = w_timer;
        STATUS:  D = {30'h0, r_status};
        default: D = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire
